// File: rtl/sparse_tree_pkg.sv
// Shared types and helpers for the sparse-tree adder sum stage.
// Nibble width is fixed at 4 to match the 4-sparse carry generator.
package sparse_tree_pkg;

   localparam int BLOCK_WIDTH = 4;

   typedef logic [BLOCK_WIDTH-1:0] nibble_t;

   function automatic int n_blocks(input int n);
      return n / BLOCK_WIDTH;
   endfunction

endpackage

// File: rtl/sparse_tree_sum_stage_carry_select_block.sv
// One carry-select nibble: both candidate sums, picked by the nibble carry-in.
// Also exposes the ripple carry into bit 3 for the signed overflow flag.
module carry_select_block
   import sparse_tree_pkg::*;
(
   input  nibble_t a,
   input  nibble_t b,
   input  logic    sel,
   output nibble_t sum,
   output logic    c_msb_in
);

   nibble_t    s0;
   nibble_t    s1;
   logic [3:0] low;

   // Precompute both candidate sums and the carry into the nibble MSB
   always_comb begin
      s0       = a + b;
      s1       = a + b + nibble_t'(1);
      sum      = sel ? s1 : s0;
      low      = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b000, sel};
      c_msb_in = low[3];
   end

endmodule

// File: rtl/sparse_tree_sum_stage.sv
// Two-stage pipelined carry-select sum stage with valid/ready flow control.
// Optional OVERFLOW_FLAG_EN adds a registered signed-overflow output.
module sparse_tree_sum_stage
   import sparse_tree_pkg::*;
#(
   parameter int N_BIT = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [N_BIT-1:0]            operand_1,
   input  logic [N_BIT-1:0]            operand_2,
   input  logic                        carry_in,
   input  logic [N_BIT/BLOCK_WIDTH-1:0] carries,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [N_BIT-1:0]            sum,
   output logic                        carry_out
`ifdef OVERFLOW_FLAG_EN
   ,
   output logic                        overflow
`endif
);

   localparam int NB = n_blocks(N_BIT);

   if ((N_BIT % BLOCK_WIDTH) != 0 || N_BIT < 8) begin : g_bad_width
      $error("sparse_tree_sum_stage: N_BIT must be a multiple of 4 and >= 8");
   end

   logic [N_BIT-1:0] a_q;
   logic [N_BIT-1:0] b_q;
   logic             cin_q;
   logic [NB-1:0]    carries_q;
   logic             s1_valid_q;

   logic [N_BIT-1:0] sum_q;
   logic [N_BIT-1:0] sum_d;
   logic             cout_q;
   logic             out_valid_q;

   logic [NB-1:0]    sel_w;
   logic [NB-1:0]    c_msb_w;
   logic             s2_adv;
   logic             s1_adv;

   // Handshake: a stage advances when its downstream slot is free or draining
   always_comb begin
      s2_adv   = !out_valid_q || out_ready;
      s1_adv   = !s1_valid_q || s2_adv;
      in_ready = s1_adv && !rst;
   end

   assign sel_w = {carries_q[NB-2:0], cin_q};

   for (genvar j = 0; j < NB; j++) begin : g_blk
      carry_select_block u_blk (
         .a        (a_q[j*BLOCK_WIDTH +: BLOCK_WIDTH]),
         .b        (b_q[j*BLOCK_WIDTH +: BLOCK_WIDTH]),
         .sel      (sel_w[j]),
         .sum      (sum_d[j*BLOCK_WIDTH +: BLOCK_WIDTH]),
         .c_msb_in (c_msb_w[j])
      );
   end

   // S1 occupancy: refilled from the input whenever the slot advances
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
      end else if (s1_adv) begin
         s1_valid_q <= in_valid;
      end
   end

   // S1 payload: captured only on an accepted input bundle
   always_ff @(posedge clk) begin
      if (in_valid && in_ready) begin
         a_q       <= operand_1;
         b_q       <= operand_2;
         cin_q     <= carry_in;
         carries_q <= carries;
      end
   end

   // S2: registered result; holds its last value when empty or stalled
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
      end else if (s2_adv) begin
         out_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            sum_q  <= sum_d;
            cout_q <= carries_q[NB-1];
         end
      end
   end

`ifdef OVERFLOW_FLAG_EN
   logic ovf_q;

   // Signed overflow: carry out of MSB differs from carry into MSB
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (s2_adv && s1_valid_q) begin
         ovf_q <= carries_q[NB-1] ^ c_msb_w[NB-1];
      end
   end

   assign overflow = ovf_q;
`else
   logic unused_c_msb;
   assign unused_c_msb = ^c_msb_w;
`endif

   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign carry_out = cout_q;

endmodule
